// File: rtl/leve_ibuf_if.sv
// Handshake bundles used by leve_ibuf.
//   axir_if : AXI read-address / read-data channels (master = init)
//   pc_if   : fetch address request; target returns READY when the word is served
//   hs_if   : instruction payload with a VALID qualifier (producer = init)
interface axir_if #(
    parameter int DW = 128
);
    logic          ARVALID;
    logic          ARREADY;
    logic [31:0]   ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          RVALID;
    logic          RREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;

    modport init (
        output ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
        input  ARREADY, RVALID, RDATA, RRESP, RLAST
    );
    modport target (
        input  ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
        output ARREADY, RVALID, RDATA, RRESP, RLAST
    );
endinterface

interface pc_if;
    logic [31:0] PC;
    logic        VALID;
    logic        READY;

    modport init   (output PC, VALID, input READY);
    modport target (input PC, VALID, output READY);
endinterface

interface hs_if;
    logic [31:0] PAYLOAD;
    logic        VALID;

    modport init   (output PAYLOAD, VALID);
    modport target (input PAYLOAD, VALID);
endinterface

// File: rtl/leve_ibuf.sv
// leve_ibuf: fully associative multi-line instruction fetch buffer.
// Lines are filled by AXI WRAP bursts starting at the critical beat; every
// beat is usable the cycle after it lands. A demand fill is optionally
// followed by a sequential next-line prefetch.
// Ports:
//   CLK, RSTn : clock, asynchronous active-low reset
//   RII       : AXI read master (ARLEN = BEATS-1, WRAP bursts, RREADY tied high)
//   PC        : fetch address request; READY = served this cycle
//   INST      : 32-bit instruction out, VALID mirrors PC.READY
//   FLUSH     : one-cycle pulse, invalidates every line (fence.i)
module leve_ibuf #(
    parameter int LINES    = 2,
    parameter int BEATS    = 4,
    parameter int DW       = 128,
    parameter int PREFETCH = 1
) (
    input  logic        CLK,
    input  logic        RSTn,
    axir_if.init        RII,
    pc_if.target        PC,
    hs_if.init          INST,
    input  logic        FLUSH
);
    localparam int LB   = BEATS * DW / 8;
    localparam int OFF  = $clog2(LB);
    localparam int BO   = $clog2(DW / 8);
    localparam int BW   = $clog2(BEATS);
    localparam int LW   = $clog2(LINES);
    localparam int TW   = 32 - OFF;
    localparam int WSEL = DW / 32;
    localparam int WW   = (WSEL > 1) ? $clog2(WSEL) : 1;

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

    state_t                       state_q, state_d;
    logic [LINES-1:0][TW-1:0]     tag_q;
    logic [LINES-1:0]             tv_q;
    logic [LINES-1:0][BEATS-1:0]  bv_q;
    logic [WSEL-1:0][31:0]        data_q [LINES][BEATS];
    logic [LW-1:0]                victim_q;
    logic [LW-1:0]                fill_q;
    logic [31:0]                  araddr_q;
    logic [BW-1:0]                cnt_q;
    logic                         pf_q;
    logic                         discard_q;

    // Request decode
    logic [TW-1:0] pc_tag;
    logic [BW-1:0] pc_beat;
    logic [WW-1:0] pc_word;
    assign pc_tag  = PC.PC[31:OFF];
    assign pc_beat = BW'(PC.PC >> BO);
    assign pc_word = WW'((PC.PC >> 2) & 32'(WSEL - 1));

    // Lookup: any_match drives allocation, hit needs the beat as well
    logic          any_match, hit;
    logic [LW-1:0] hit_line;
    always_comb begin
        any_match = 1'b0;
        hit       = 1'b0;
        hit_line  = '0;
        for (int i = 0; i < LINES; i++) begin
            if (tv_q[i] && tag_q[i] == pc_tag) begin
                any_match = 1'b1;
                if (bv_q[i][pc_beat]) begin
                    hit      = 1'b1;
                    hit_line = LW'(i);
                end
            end
        end
    end

    logic served;
    assign served       = PC.VALID & hit & ~FLUSH;
    assign PC.READY     = served;
    assign INST.VALID   = served;
    assign INST.PAYLOAD = data_q[hit_line][pc_beat][pc_word];

    // Next-line candidate: line following the one just fetched
    logic [TW-1:0] nxt_tag;
    logic          nxt_match;
    assign nxt_tag = araddr_q[31:OFF] + TW'(1);
    always_comb begin
        nxt_match = 1'b0;
        for (int i = 0; i < LINES; i++)
            if (tv_q[i] && tag_q[i] == nxt_tag) nxt_match = 1'b1;
    end

    logic r_fire, beat_keep;
    assign r_fire    = (state_q == S_R) && RII.RVALID;
    assign beat_keep = r_fire && !discard_q && !FLUSH;

    // FSM: next state and allocation strobes
    logic alloc_dem, alloc_pf, ar_valid;
    always_comb begin
        state_d   = state_q;
        alloc_dem = 1'b0;
        alloc_pf  = 1'b0;
        ar_valid  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // FLUSH suppresses allocation; the miss is seen again next cycle
                if (PC.VALID && !any_match && !FLUSH) begin
                    alloc_dem = 1'b1;
                    state_d   = S_AR;
                end
            end
            S_AR: begin
                ar_valid = 1'b1;
                if (RII.ARREADY) state_d = S_R;
            end
            S_R: begin
                if (RII.RVALID && RII.RLAST) begin
                    if (!pf_q && PREFETCH != 0 && !discard_q && !FLUSH && !nxt_match) begin
                        alloc_pf = 1'b1;
                        state_d  = S_AR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Tag / valid / fill bookkeeping
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            tag_q     <= '0;
            tv_q      <= '0;
            bv_q      <= '0;
            victim_q  <= '0;
            fill_q    <= '0;
            araddr_q  <= '0;
            cnt_q     <= '0;
            pf_q      <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            if (beat_keep) bv_q[fill_q][cnt_q] <= 1'b1;
            if (r_fire)    cnt_q <= cnt_q + BW'(1);
            // Burst starts at the critical beat and wraps within the line
            if (state_q == S_AR && RII.ARREADY) cnt_q <= araddr_q[OFF-1:BO];
            if (alloc_dem || alloc_pf) begin
                tag_q[victim_q] <= alloc_dem ? pc_tag : nxt_tag;
                tv_q[victim_q]  <= 1'b1;
                bv_q[victim_q]  <= '0;
                victim_q        <= victim_q + LW'(1);
                fill_q          <= victim_q;
                araddr_q        <= alloc_dem ? {PC.PC[31:BO], {BO{1'b0}}}
                                             : {nxt_tag, {OFF{1'b0}}};
                pf_q            <= alloc_pf;
            end
            // Leaving to IDLE always drops the discard, even if FLUSH coincides
            if (state_d == S_IDLE)                discard_q <= 1'b0;
            else if (FLUSH && state_q != S_IDLE)  discard_q <= 1'b1;
            if (FLUSH) begin
                tv_q     <= '0;
                bv_q     <= '0;
                victim_q <= '0;
            end
        end
    end

    // Line data: qualified by the beat-valid bits, so no reset needed
    always_ff @(posedge CLK) begin
        if (beat_keep) data_q[fill_q][cnt_q] <= RII.RDATA;
    end

    assign RII.ARVALID = ar_valid;
    assign RII.ARADDR  = araddr_q;
    assign RII.ARLEN   = 8'(BEATS - 1);
    assign RII.ARSIZE  = 3'(BO);
    assign RII.ARBURST = 2'b10;
    assign RII.RREADY  = 1'b1;

    logic unused_resp;
    assign unused_resp = ^RII.RRESP;
endmodule

// File: tb/tb_leve_ibuf.sv
// Directed bench for leve_ibuf with default parameters (2 lines x 4 beats x 128b).
// Beat data is the byte address of each word, so the expected payload for a
// served PC is the PC itself.
module tb_leve_ibuf;
    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic FLUSH = 1'b0;
    int   checks = 0;
    int   failures = 0;

    axir_if #(.DW(128)) rii();
    pc_if                pci();
    hs_if                ins();

    leve_ibuf #(.LINES(2), .BEATS(4), .DW(128), .PREFETCH(1)) dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .RII  (rii),
        .PC   (pci),
        .INST (ins),
        .FLUSH(FLUSH)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [127:0] mkbeat(input logic [31:0] a);
        return {a + 32'd12, a + 32'd8, a + 32'd4, a};
    endfunction

    task automatic ar_accept();
        rii.ARREADY = 1'b1;
        tick();
        rii.ARREADY = 1'b0;
    endtask

    task automatic r_beat(input logic [31:0] base, input int beat, input bit last);
        rii.RVALID = 1'b1;
        rii.RDATA  = mkbeat(base + 32'(16 * beat));
        rii.RLAST  = last;
        tick();
        rii.RVALID = 1'b0;
        rii.RLAST  = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] a, input logic v);
        pci.PC    = a;
        pci.VALID = v;
        #1;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        rii.ARREADY = 1'b0; rii.RVALID = 1'b0; rii.RLAST = 1'b0;
        rii.RDATA = '0; rii.RRESP = 2'b00;
        set_pc(32'h1000, 1'b1);
        checks++; if (rii.ARVALID !== 1'b0) begin failures++; $display("FAIL rst_arvalid got=%b exp=0", rii.ARVALID); end
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL rst_ivalid got=%b exp=0", ins.VALID); end
        checks++; if (pci.READY !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", pci.READY); end
        checks++; if (rii.RREADY !== 1'b1) begin failures++; $display("FAIL rst_rready got=%b exp=1", rii.RREADY); end
        pci.VALID = 1'b0;
        tick();
        RSTn = 1'b1;
        tick();
    endtask

    task automatic test_demand_fill();
        set_pc(32'h1000, 1'b1);
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL miss_ivalid got=%b exp=0", ins.VALID); end
        tick();
        checks++; if (rii.ARVALID !== 1'b1) begin failures++; $display("FAIL dem_arvalid got=%b exp=1", rii.ARVALID); end
        checks++; if (rii.ARADDR !== 32'h1000) begin failures++; $display("FAIL dem_araddr got=%h exp=1000", rii.ARADDR); end
        checks++; if (rii.ARLEN !== 8'd3) begin failures++; $display("FAIL dem_arlen got=%0d exp=3", rii.ARLEN); end
        checks++; if (rii.ARBURST !== 2'b10) begin failures++; $display("FAIL dem_arburst got=%b exp=10", rii.ARBURST); end
        checks++; if (rii.ARSIZE !== 3'd4) begin failures++; $display("FAIL dem_arsize got=%0d exp=4", rii.ARSIZE); end
        ar_accept();
        checks++; if (rii.ARVALID !== 1'b0) begin failures++; $display("FAIL ar_drop got=%b exp=0", rii.ARVALID); end
        r_beat(32'h1000, 0, 1'b0);
        checks++; if (ins.VALID !== 1'b1 || ins.PAYLOAD !== 32'h1000) begin failures++; $display("FAIL beat0_hit got=%b/%h exp=1/1000", ins.VALID, ins.PAYLOAD); end
        set_pc(32'h100C, 1'b1);
        checks++; if (ins.PAYLOAD !== 32'h100C) begin failures++; $display("FAIL word3 got=%h exp=100c", ins.PAYLOAD); end
        r_beat(32'h1000, 1, 1'b0);
        r_beat(32'h1000, 2, 1'b0);
        r_beat(32'h1000, 3, 1'b1);
        checks++; if (rii.ARVALID !== 1'b1 || rii.ARADDR !== 32'h1040) begin failures++; $display("FAIL pf_ar got=%b/%h exp=1/1040", rii.ARVALID, rii.ARADDR); end
        checks++; if (rii.ARLEN !== 8'd3) begin failures++; $display("FAIL pf_arlen got=%0d exp=3", rii.ARLEN); end
        set_pc(32'h1030, 1'b1);
        checks++; if (ins.VALID !== 1'b1 || ins.PAYLOAD !== 32'h1030) begin failures++; $display("FAIL hit_in_ar got=%b/%h exp=1/1030", ins.VALID, ins.PAYLOAD); end
        ar_accept();
        for (int b = 0; b < 4; b++) r_beat(32'h1040, b, b == 3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int i = 0; i < 20; i++) begin
            a = ((i % 2) == 0 ? 32'h1000 : 32'h1040) + 32'((i * 4) % 64);
            set_pc(a, 1'b1);
            checks++; if (ins.VALID !== 1'b1 || ins.PAYLOAD !== a) begin failures++; $display("FAIL b2b[%0d] got=%b/%h exp=1/%h", i, ins.VALID, ins.PAYLOAD, a); end
            checks++; if (rii.ARVALID !== 1'b0) begin failures++; $display("FAIL b2b_ar[%0d] got=%b exp=0", i, rii.ARVALID); end
            tick();
        end
        pci.VALID = 1'b0;
    endtask

    task automatic test_critical_word();
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        set_pc(32'h1000, 1'b1);
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL flushed_idle got=%b exp=0", ins.VALID); end
        set_pc(32'h1024, 1'b1);
        tick();
        checks++; if (rii.ARADDR !== 32'h1020) begin failures++; $display("FAIL crit_araddr got=%h exp=1020", rii.ARADDR); end
        ar_accept();
        r_beat(32'h1000, 2, 1'b0);
        checks++; if (ins.VALID !== 1'b1 || ins.PAYLOAD !== 32'h1024) begin failures++; $display("FAIL crit_first got=%b/%h exp=1/1024", ins.VALID, ins.PAYLOAD); end
        set_pc(32'h1030, 1'b1);
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL beat3_early got=%b exp=0", ins.VALID); end
        r_beat(32'h1000, 3, 1'b0);
        checks++; if (ins.VALID !== 1'b1 || ins.PAYLOAD !== 32'h1030) begin failures++; $display("FAIL beat3 got=%b/%h exp=1/1030", ins.VALID, ins.PAYLOAD); end
        set_pc(32'h1000, 1'b1);
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL beat0_early got=%b exp=0", ins.VALID); end
        r_beat(32'h1000, 0, 1'b0);
        checks++; if (ins.VALID !== 1'b1 || ins.PAYLOAD !== 32'h1000) begin failures++; $display("FAIL wrap_beat0 got=%b/%h exp=1/1000", ins.VALID, ins.PAYLOAD); end
        set_pc(32'h1018, 1'b1);
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL beat1_early got=%b exp=0", ins.VALID); end
        r_beat(32'h1000, 1, 1'b1);
        checks++; if (ins.VALID !== 1'b1 || ins.PAYLOAD !== 32'h1018) begin failures++; $display("FAIL beat1 got=%b/%h exp=1/1018", ins.VALID, ins.PAYLOAD); end
        checks++; if (rii.ARVALID !== 1'b1 || rii.ARADDR !== 32'h1040) begin failures++; $display("FAIL crit_pf got=%b/%h exp=1/1040", rii.ARVALID, rii.ARADDR); end
        ar_accept();
        for (int b = 0; b < 4; b++) r_beat(32'h1040, b, b == 3);
    endtask

    task automatic test_evict();
        set_pc(32'h2000, 1'b1);
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL ev_miss got=%b exp=0", ins.VALID); end
        tick();
        checks++; if (rii.ARADDR !== 32'h2000) begin failures++; $display("FAIL ev_araddr got=%h exp=2000", rii.ARADDR); end
        ar_accept();
        for (int b = 0; b < 4; b++) r_beat(32'h2000, b, b == 3);
        checks++; if (rii.ARVALID !== 1'b1 || rii.ARADDR !== 32'h2040) begin failures++; $display("FAIL ev_pf got=%b/%h exp=1/2040", rii.ARVALID, rii.ARADDR); end
        ar_accept();
        for (int b = 0; b < 4; b++) r_beat(32'h2040, b, b == 3);
        set_pc(32'h1000, 1'b1);
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL ev_1000 got=%b exp=0", ins.VALID); end
        set_pc(32'h1040, 1'b1);
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL ev_1040 got=%b exp=0", ins.VALID); end
        set_pc(32'h2048, 1'b1);
        checks++; if (ins.VALID !== 1'b1 || ins.PAYLOAD !== 32'h2048) begin failures++; $display("FAIL ev_2048 got=%b/%h exp=1/2048", ins.VALID, ins.PAYLOAD); end
        pci.VALID = 1'b0;
        tick();
    endtask

    task automatic test_flush_burst();
        set_pc(32'h1000, 1'b1);
        tick();
        checks++; if (rii.ARVALID !== 1'b1 || rii.ARADDR !== 32'h1000) begin failures++; $display("FAIL fl_ar got=%b/%h exp=1/1000", rii.ARVALID, rii.ARADDR); end
        ar_accept();
        r_beat(32'h1000, 0, 1'b0);
        checks++; if (ins.VALID !== 1'b1) begin failures++; $display("FAIL fl_beat0 got=%b exp=1", ins.VALID); end
        rii.RVALID = 1'b1;
        rii.RDATA  = mkbeat(32'h1010);
        FLUSH = 1'b1;
        #1;
        checks++; if (ins.VALID !== 1'b0 || pci.READY !== 1'b0) begin failures++; $display("FAIL flush_wins got=%b/%b exp=0/0", ins.VALID, pci.READY); end
        tick();
        FLUSH = 1'b0;
        rii.RVALID = 1'b0;
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL fl_after got=%b exp=0", ins.VALID); end
        r_beat(32'h1000, 2, 1'b0);
        checks++; if (ins.VALID !== 1'b0 || rii.RREADY !== 1'b1) begin failures++; $display("FAIL fl_beat2 got=%b/%b exp=0/1", ins.VALID, rii.RREADY); end
        set_pc(32'h1030, 1'b1);
        r_beat(32'h1000, 3, 1'b1);
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL fl_beat3 got=%b exp=0", ins.VALID); end
        checks++; if (rii.ARVALID !== 1'b0) begin failures++; $display("FAIL fl_nopf got=%b exp=0", rii.ARVALID); end
        set_pc(32'h1000, 1'b1);
        tick();
        checks++; if (rii.ARVALID !== 1'b1 || rii.ARADDR !== 32'h1000) begin failures++; $display("FAIL fl_rearm got=%b/%h exp=1/1000", rii.ARVALID, rii.ARADDR); end
    endtask

    task automatic test_async_reset();
        ar_accept();
        r_beat(32'h1000, 0, 1'b0);
        checks++; if (ins.VALID !== 1'b1) begin failures++; $display("FAIL ar_pre got=%b exp=1", ins.VALID); end
        #1;
        RSTn = 1'b0;
        #1;
        checks++; if (rii.ARVALID !== 1'b0 || ins.VALID !== 1'b0 || pci.READY !== 1'b0) begin failures++; $display("FAIL async_rst got=%b/%b/%b exp=0/0/0", rii.ARVALID, ins.VALID, pci.READY); end
        tick();
        RSTn = 1'b1;
        #1;
        checks++; if (ins.VALID !== 1'b0) begin failures++; $display("FAIL post_rst got=%b exp=0", ins.VALID); end
        tick();
        checks++; if (rii.ARVALID !== 1'b1 || rii.ARADDR !== 32'h1000) begin failures++; $display("FAIL post_rst_ar got=%b/%h exp=1/1000", rii.ARVALID, rii.ARADDR); end
        pci.VALID = 1'b0;
    endtask

    initial begin
        test_reset();
        test_demand_fill();
        test_back_to_back();
        test_critical_word();
        test_evict();
        test_flush_burst();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
